// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - default address/data widths
//   - fetch FSM state encoding (BOOT/RUN/HALT)
//   - NOP encoding used as the reset value of the output instruction register
//   - small helper that qualifies an accepted output transfer
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A transfer only counts as accepted when it is not dropped by a flush
    // in the same cycle.
    function automatic logic is_accept(input logic valid, input logic ready,
                                       input logic flush);
        return valid & ready & ~flush;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the fetch stage's bus signals:
//   imem_addr/imem_data          : instruction memory (combinational read)
//   redirect_valid/redirect_pc   : branch/jump redirect and flush
//   halt_req/halted              : halt request and halted status
//   out_valid/out_ready          : handshake towards decode
//   out_instr/out_pc             : fetched instruction and its PC
// Modports:
//   master : the fetch stage
//   slave  : the environment (memory, decode, control)
// -----------------------------------------------------------------------------
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              halted;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted
    );

endinterface

// File: rtl/instr_fetch_perf.sv
// -----------------------------------------------------------------------------
// instr_fetch_perf
// Pair of 32-bit saturating event counters for the fetch stage.
// Ports:
//   clk_i        : clock
//   reset_n_i    : synchronous active-low reset, clears both counters
//   fetch_inc_i  : count one accepted transfer
//   stall_inc_i  : count one stalled cycle (valid held, not ready)
//   fetch_cnt_o  : accepted transfer count
//   stall_cnt_o  : stall cycle count
// -----------------------------------------------------------------------------
module instr_fetch_perf (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fetch_inc_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (stall_inc_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: owns the PC, presents it to instruction memory, registers the
// combinationally returned word together with its PC and offers it to decode
// over a valid/ready handshake. Supports redirect (flush), halt and a short
// boot delay after reset.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : instr_fetch_if.master (imem, redirect, halt, output handshake)
//   perf_fetch_cnt / perf_stall_cnt : only with INSTR_FETCH_PERF_EN defined
// Optional feature macro: INSTR_FETCH_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    instr_fetch_if.master bus
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    fetch_state_e      state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [BOOT_W-1:0] boot_cnt_q,  boot_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q,    out_pc_d;
    logic              halted_q;

    logic              load_en_s;
    logic              redir_s;

    // Output register may be refilled when empty or being drained this cycle.
    assign load_en_s = ~out_valid_q | bus.out_ready;
    // Redirects are ignored while still booting.
    assign redir_s   = bus.redirect_valid & (state_q != ST_BOOT);

    // Next-state and datapath decisions.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        boot_cnt_d  = boot_cnt_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            ST_BOOT: begin
                out_valid_d = 1'b0;
                boot_cnt_d  = boot_cnt_q + BOOT_W'(1);
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (redir_s) begin
                    // Flush: drop held output, no capture this cycle.
                    pc_d        = bus.redirect_pc;
                    out_valid_d = 1'b0;
                end else if (load_en_s) begin
                    if (bus.halt_req) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_HALT;
                    end else begin
                        out_instr_d = bus.imem_data;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + ADDR_W'(1);
                    end
                end else begin
                    // Stalled: everything holds.
                    out_valid_d = out_valid_q;
                end
            end
            ST_HALT: begin
                out_valid_d = 1'b0;
                if (redir_s) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d     = ST_BOOT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            boot_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= DATA_W'(NOP_INSTR);
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            boot_cnt_q  <= boot_cnt_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= (state_d == ST_HALT);
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.halted    = halted_q;

`ifdef INSTR_FETCH_PERF_EN
    logic accept_s;
    logic stall_s;

    assign accept_s = is_accept(out_valid_q, bus.out_ready, redir_s);
    assign stall_s  = out_valid_q & ~bus.out_ready;

    instr_fetch_perf u_perf (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .fetch_inc_i (accept_s),
        .stall_inc_i (stall_s),
        .fetch_cnt_o (perf_fetch_cnt),
        .stall_cnt_o (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed steps plus a randomized phase,
// all compared against a behavioural reference model.
module tb_instr_fetch;
    localparam int AW    = 22;
    localparam int DW    = 32;
    localparam int BOOTC = 1;
    localparam int PCMOD = 1 << AW;

    logic clk;
    logic reset_n;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RESET_PC    (22'd0),
        .BOOT_CYCLES (BOOTC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Memory content: word[i] = i + 100.
    function automatic logic [31:0] word(input int a);
        return 32'(a) + 32'd100;
    endfunction

    assign bus.imem_data = {10'd0, bus.imem_addr} + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state (post-edge view).
    int  m_mode;      // 0 boot, 1 run, 2 halt
    int  m_boot_left;
    int  m_pc;
    bit  m_valid;
    int  m_out_pc;
    int  m_out_instr;
    longint m_fetch;
    longint m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the current input values.
    task automatic model_step();
        bit rv;
        rv = (bus.redirect_valid === 1'b1) && (m_mode != 0);
        if (reset_n !== 1'b1) begin
            m_mode = 0; m_boot_left = BOOTC; m_pc = 0;
            m_valid = 0; m_out_pc = 0; m_out_instr = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            if (m_valid && bus.out_ready && !rv && m_fetch < 64'hFFFF_FFFF) m_fetch++;
            if (m_valid && !bus.out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_mode == 0) begin
                m_boot_left--;
                if (m_boot_left == 0) m_mode = 1;
            end else if (rv) begin
                m_pc = int'(bus.redirect_pc);
                m_valid = 0;
                m_mode = 1;
            end else if (m_mode == 1 && (!m_valid || bus.out_ready)) begin
                if (bus.halt_req) begin
                    m_valid = 0;
                    m_mode = 2;
                end else begin
                    m_out_pc = m_pc;
                    m_out_instr = int'(word(m_pc));
                    m_valid = 1;
                    m_pc = (m_pc + 1) % PCMOD;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("halted", 32'(bus.halted), (m_mode == 2) ? 32'd1 : 32'd0);
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        if (m_valid) begin
            chk("out_pc", 32'(bus.out_pc), 32'(m_out_pc));
            chk("out_instr", bus.out_instr, 32'(m_out_instr));
        end
`ifdef INSTR_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
        chk("perf_stall", perf_stall_cnt, 32'(m_stall));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 22'd0;
        bus.halt_req = 1'b0;
        m_mode = 0; m_boot_left = BOOTC; m_pc = 0; m_valid = 0;
        m_out_pc = 0; m_out_instr = 0; m_fetch = 0; m_stall = 0;
        #2;

        // Reset state.
        tick(); tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);

        // Boot then stream 0..2.
        reset_n = 1'b1;
        tick();
        chk("boot_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("s0_pc", 32'(bus.out_pc), 32'd0);
        chk("s0_instr", bus.out_instr, 32'd100);
        tick();
        chk("s1_instr", bus.out_instr, 32'd101);
        tick();
        chk("s2_pc", 32'(bus.out_pc), 32'd2);

        // Stall three cycles holding pc 2.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(bus.out_pc), 32'd2);
            chk("stall_instr", bus.out_instr, 32'd102);
            chk("stall_addr", 32'(bus.imem_addr), 32'd3);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_pc", 32'(bus.out_pc), 32'd3);
        tick(); tick();
        chk("s5_pc", 32'(bus.out_pc), 32'd5);

        // Redirect drops pc 5.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 22'd255;
        tick();
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        chk("redir_pc", 32'(bus.out_pc), 32'd255);
        chk("redir_instr", bus.out_instr, 32'd355);

        // PC wrap.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 22'h3FFFFF;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("wrap_top", 32'(bus.out_pc), 32'd4194303);
        tick();
        chk("wrap_zero", 32'(bus.out_pc), 32'd0);

        // Halt, stay frozen, redirect out.
        bus.halt_req = 1'b1;
        tick();
        chk("halt_valid", 32'(bus.out_valid), 32'd0);
        chk("halt_flag", 32'(bus.halted), 32'd1);
        bus.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_frozen", 32'(bus.imem_addr), 32'd1);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 22'd8;
        tick();
        chk("unhalt_flag", 32'(bus.halted), 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        chk("unhalt_pc", 32'(bus.out_pc), 32'd8);

        // Reset mid-stall.
        bus.out_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_pc", 32'(bus.out_pc), 32'd0);
        chk("mrst_instr", bus.out_instr, 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk("mrst_pf", perf_fetch_cnt, 32'd0);
        chk("mrst_ps", perf_stall_cnt, 32'd0);
`endif

        // Redirect during boot is ignored.
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 22'd77;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("bootredir_pc", 32'(bus.out_pc), 32'd0);

        // Randomized phase.
        for (int i = 0; i < 500; i++) begin
            reset_n = ($urandom % 150) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            bus.halt_req = ($urandom % 20) == 0;
            bus.redirect_valid = ($urandom % 14) == 0;
            if (($urandom % 4) == 0)
                bus.redirect_pc = 22'(22'h3FFFFF - 22'($urandom_range(0, 3)));
            else
                bus.redirect_pc = 22'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of the instruction memory. It owns the program counter and drives the word address into instruction memory. Memory read is combinational and returns data in the same cycle. The stage registers each returned word with its PC and hands it to decode over a valid/ready handshake. It also supports branch/jump redirect, flush, and halt.

Parameters:
ADDR_W, 22, PC / memory word-address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
BOOT_CYCLES, 1, cycles spent in BOOT after reset release before fetching (min 1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
imem_addr  out  ADDR_W  word address to instruction memory (= pc register)
imem_data  in  DATA_W  instruction word returned combinationally for imem_addr
redirect_valid  in  1  load redirect_pc and flush the output register
redirect_pc  in  ADDR_W  redirect target
halt_req  in  1  stop fetching after the current output is consumed
out_valid  out  1  out_instr/out_pc hold a valid fetched instruction
out_ready  in  1  decode accepts when out_valid & out_ready
out_instr  out  DATA_W  fetched instruction
out_pc  out  ADDR_W  PC of out_instr
halted  out  1  high while in HALT state

Behaviour:
- Reset (reset_n=0 at edge):
  - pc=RESET_PC; state=BOOT; boot counter=0.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - Reset wins over all other inputs, including mid-transfer; any pending output is discarded.
- imem_addr equals the pc register with no combinational path from inputs.
- FSM states: BOOT, RUN, HALT.
  - BOOT: out_valid stays 0. Boot counter increments each cycle. After BOOT_CYCLES cycles -> RUN.
  - RUN: load enable = ~out_valid | out_ready. When load enable is high:
    - out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+1.
    - PC increment is modulo 2^ADDR_W: 2^22-1 wraps to 0.
  - RUN with halt_req=1 and load enable high: no new capture, out_valid<=0, state->HALT. With load enable low, stay in RUN until the held output is accepted.
  - HALT: halted=1, out_valid=0, pc frozen. Exit only via redirect_valid, which goes to RUN.
- Redirect, in any state except BOOT:
  - pc<=redirect_pc and out_valid<=0; the instruction currently in the output register is dropped even if out_ready=1 that cycle.
  - No capture in the redirect cycle. The first instruction at redirect_pc appears with out_valid=1 one cycle later (redirect-to-valid latency 1).
  - Redirect beats halt_req when both are asserted in the same cycle.
  - Redirect during BOOT is ignored.
- Throughput: one instruction per cycle while out_ready=1.
  - Latency: pc visible on imem_addr in cycle N -> out_valid with that word in cycle N+1.
- Stall: while out_valid=1 and out_ready=0, out_instr, out_pc and pc hold stable.
- Handshake rule: once out_valid rises, out_instr and out_pc do not change until accepted or flushed by redirect/reset.

Optional Feature:
INSTR_FETCH_PERF_EN:
- With the macro defined: two 32-bit outputs are present.
  - perf_fetch_cnt increments on each accepted transfer.
  - perf_stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - Both clear on reset and saturate at 32'hFFFFFFFF.
- Without the macro: the ports and counters are absent.

Decomposition:
- Shared package/header holds: ADDR_W/DATA_W defaults, FSM encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), NOP encoding 32'h0000_0000 used as the reset value of out_instr.
- One natural sub-module: instr_fetch_perf, the saturating counter pair, instantiated only under INSTR_FETCH_PERF_EN.
- All other logic stays in instr_fetch.

Test Plan:
- Reset then out_ready=1 and memory word[i]=i+100 -> after the BOOT cycle, out_pc=0,1,2,3 on consecutive cycles with out_instr=100,101,102,103; halted=0.
- out_ready=0 for 3 cycles while out_pc=2 -> out_pc=2, out_instr=102 and imem_addr=3 held all 3 cycles; release -> out_pc=3 next cycle.
- redirect_valid=1, redirect_pc=255 while out_pc=5 is valid -> next cycle out_valid=0; following cycle out_pc=255, out_instr=word[255]; the word at PC 5 is never accepted.
- pc=2^22-1 with out_ready=1 -> out_pc=4194303, then out_pc=0.
- halt_req=1 with out_ready=1 -> next cycle out_valid=0 and halted=1; pc frozen for 5 cycles; redirect_pc=8 -> halted=0, then out_pc=8.
- reset_n=0 asserted mid-stall with out_valid=1 -> next cycle out_valid=0, out_pc=0, out_instr=0, state BOOT; with INSTR_FETCH_PERF_EN both counters read 0.
